// File: rtl/card_disp_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : card_disp_pkg                                                   |
// | Purpose  : Shared types, 7-segment patterns and card decode function for  |
// |            the card display bank.                                          |
// | Encoding : active-low segments, bit6 = g ... bit0 = a                      |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
package card_disp_pkg;

  typedef logic [3:0] card_t;
  typedef logic [6:0] seg7_t;

  typedef enum logic {
    IDLE   = 1'b0,
    REVEAL = 1'b1
  } disp_state_t;

  localparam seg7_t SEG_BLANK = 7'b1111111;
  localparam seg7_t SEG_DASH  = 7'b0111111;
  localparam seg7_t SEG_ACE   = 7'b0001000;
  localparam seg7_t SEG_TWO   = 7'b0100100;
  localparam seg7_t SEG_THREE = 7'b0110000;
  localparam seg7_t SEG_FOUR  = 7'b0011001;
  localparam seg7_t SEG_FIVE  = 7'b0010010;
  localparam seg7_t SEG_SIX   = 7'b0000010;
  localparam seg7_t SEG_SEVEN = 7'b1111000;
  localparam seg7_t SEG_EIGHT = 7'b0000000;
  localparam seg7_t SEG_NINE  = 7'b0010000;
  localparam seg7_t SEG_TEN   = 7'b1000000;
  localparam seg7_t SEG_JACK  = 7'b1100001;
  localparam seg7_t SEG_QUEEN = 7'b0011000;
  localparam seg7_t SEG_KING  = 7'b0001001;

  // Codes 0, 14 and 15 are not cards and render as an unlit digit.
  function automatic seg7_t card_to_seg7(input card_t card);
    seg7_t seg;
    case (card)
      4'd1:    seg = SEG_ACE;
      4'd2:    seg = SEG_TWO;
      4'd3:    seg = SEG_THREE;
      4'd4:    seg = SEG_FOUR;
      4'd5:    seg = SEG_FIVE;
      4'd6:    seg = SEG_SIX;
      4'd7:    seg = SEG_SEVEN;
      4'd8:    seg = SEG_EIGHT;
      4'd9:    seg = SEG_NINE;
      4'd10:   seg = SEG_TEN;
      4'd11:   seg = SEG_JACK;
      4'd12:   seg = SEG_QUEEN;
      4'd13:   seg = SEG_KING;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage
`default_nettype wire

// File: rtl/card_seg_decode.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : card_seg_decode                                                 |
// | Purpose  : Combinational card code to active-low 7-segment decoder.        |
// | Ports    : card (in, 4b card code), seg (out, 7b segments, bit6=g..a)      |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module card_seg_decode
  import card_disp_pkg::*;
(
  input  card_t card,
  output seg7_t seg
);

  assign seg = card_to_seg7(card);

endmodule
`default_nettype wire

// File: rtl/card_display_bank.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : card_display_bank                                               |
// | Purpose  : Holds NUM_SLOTS card codes and drives one active-low 7-segment  |
// |            digit per slot. Cards arrive over a valid/ready port; the       |
// |            target slot shows a dash for REVEAL_CYCLES clocks before the    |
// |            card is committed and decoded.                                  |
// | Ports    : clk, reset (async, active-high), clear (sync clear/abort),      |
// |            load_valid/load_ready/load_slot/load_card (load port),          |
// |            busy (reveal in progress), seg7 (per-slot segments).            |
// | Config   : CARD_DISP_BLINK_EN - reveal alternates dash/blank each clock    |
// |            starting with dash; undefined gives a steady dash.              |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module card_display_bank
  import card_disp_pkg::*;
#(
  parameter  int NUM_SLOTS     = 6,
  parameter  int REVEAL_CYCLES = 4,
  localparam int SLOT_W        = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
)
(
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     load_valid,
  output logic                     load_ready,
  input  logic [SLOT_W-1:0]        load_slot,
  input  card_t                    load_card,
  output logic                     busy,
  output seg7_t [NUM_SLOTS-1:0]    seg7
);

  localparam int              CNT_W    = (REVEAL_CYCLES > 1) ? $clog2(REVEAL_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REVEAL_CYCLES - 1);

  disp_state_t             state, state_next;
  logic [CNT_W-1:0]        cnt, cnt_next;
  logic [SLOT_W-1:0]       tgt_slot;
  card_t                   tgt_card;
  card_t [NUM_SLOTS-1:0]   slots;
  seg7_t [NUM_SLOTS-1:0]   dec_seg;
  seg7_t                   reveal_seg;
  logic                    accept;
  logic                    in_range;
  logic                    commit;

  assign in_range   = int'(load_slot) < NUM_SLOTS;
  assign load_ready = (state == IDLE) && !clear;
  assign busy       = (state == REVEAL);
  // An out-of-range slot still completes the handshake; it is simply dropped.
  assign accept     = load_valid && load_ready;

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    commit     = 1'b0;
    if (clear) begin
      state_next = IDLE;
      cnt_next   = '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept && in_range) begin
            state_next = REVEAL;
            cnt_next   = CNT_LAST;
          end
        end
        REVEAL: begin
          if (cnt != '0) begin
            cnt_next = cnt - CNT_W'(1);
          end else begin
            commit     = 1'b1;
            state_next = IDLE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Slot storage and the pending card. accept and commit are mutually
  // exclusive (IDLE vs REVEAL), so one write port per edge suffices.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slots    <= '0;
      tgt_slot <= '0;
      tgt_card <= '0;
    end else if (clear) begin
      slots <= '0;
    end else begin
      if (accept && in_range) begin
        tgt_slot <= load_slot;
        tgt_card <= load_card;
      end
      if (commit) begin
        slots[tgt_slot] <= tgt_card;
      end
    end
  end

`ifdef CARD_DISP_BLINK_EN
  // First reveal cycle has cnt == CNT_LAST, so matching parity means dash.
  assign reveal_seg = ((cnt[0] ^ CNT_LAST[0]) != 1'b0) ? SEG_BLANK : SEG_DASH;
`else
  assign reveal_seg = SEG_DASH;
`endif

  for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
    card_seg_decode u_dec (
      .card (slots[i]),
      .seg  (dec_seg[i])
    );
    assign seg7[i] = (busy && (tgt_slot == SLOT_W'(i))) ? reveal_seg : dec_seg[i];
  end

endmodule
`default_nettype wire

// File: tb/tb_card_display_bank.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_card_display_bank                                            |
// | Purpose  : Scoreboard bench for card_display_bank (6 slots, 4-cycle        |
// |            reveal). Stimulus pushes per-cycle expectations; a monitor on   |
// |            the falling edge pops and compares.                             |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_card_display_bank;

  localparam logic [6:0] BL  = 7'b1111111;
  localparam logic [6:0] DA  = 7'b0111111;

  logic             clk = 1'b0;
  logic             reset;
  logic             clear;
  logic             load_valid;
  logic             load_ready;
  logic [2:0]       load_slot;
  logic [3:0]       load_card;
  logic             busy;
  logic [5:0][6:0]  seg7;

  typedef struct packed {
    logic [5:0][6:0] seg;
    logic            busy;
    logic            ready;
  } exp_t;

  exp_t       q[$];
  exp_t       mon_e;
  logic [6:0] exp_seg [6];
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  card_display_bank #(
    .NUM_SLOTS     (6),
    .REVEAL_CYCLES (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .clear      (clear),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_slot  (load_slot),
    .load_card  (load_card),
    .busy       (busy),
    .seg7       (seg7)
  );

  always @(negedge clk) begin
    if (!reset && q.size() > 0) begin
      mon_e = q.pop_front();
      checks++;
      if (busy !== mon_e.busy) begin
        errors++;
        $display("FAIL busy @%0t: got %b expected %b", $time, busy, mon_e.busy);
      end
      checks++;
      if (load_ready !== mon_e.ready) begin
        errors++;
        $display("FAIL load_ready @%0t: got %b expected %b", $time, load_ready, mon_e.ready);
      end
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (seg7[i] !== mon_e.seg[i]) begin
          errors++;
          $display("FAIL seg7[%0d] @%0t: got %b expected %b", i, $time, seg7[i], mon_e.seg[i]);
        end
      end
    end
  end

  // Drive one cycle's inputs, record what the outputs must be in that cycle.
  task automatic cyc(input logic v, input logic [2:0] s, input logic [3:0] c,
                     input logic clr, input logic eb, input logic er);
    exp_t e;
    load_valid = v;
    load_slot  = s;
    load_card  = c;
    clear      = clr;
    for (int i = 0; i < 6; i++) e.seg[i] = exp_seg[i];
    e.busy  = eb;
    e.ready = er;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [6:0] rpat(input int k);
`ifdef CARD_DISP_BLINK_EN
    return (k % 2 == 1) ? BL : DA;
`else
    return DA;
`endif
  endfunction

  // Accept cycle, four reveal cycles; final value is checked by the next cycle.
  task automatic do_load(input logic [2:0] s, input logic [3:0] c, input logic [6:0] fin);
    cyc(1'b1, s, c, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      exp_seg[s] = rpat(k);
      cyc(1'b0, 3'd0, 4'd0, 1'b0, 1'b1, 1'b0);
    end
    exp_seg[s] = fin;
  endtask

  logic [3:0] tcard [9];
  logic [6:0] tseg  [9];

  initial begin
    tcard = '{4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd11, 4'd12};
    tseg  = '{7'b0100100, 7'b0110000, 7'b0011001, 7'b0010010, 7'b0000010,
              7'b1111000, 7'b0000000, 7'b1100001, 7'b0011000};
    reset = 1'b1; clear = 1'b0; load_valid = 1'b0; load_slot = '0; load_card = '0;
    for (int i = 0; i < 6; i++) exp_seg[i] = BL;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset state
    cyc(1'b0, 3'd0, 4'd0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 3'd0, 4'd0, 1'b0, 1'b0, 1'b1);

    // Single load: slot 2 king
    do_load(3'd2, 4'd13, 7'b0001001);
    cyc(1'b0, 3'd0, 4'd0, 1'b0, 1'b0, 1'b1);

    // Back-to-back: slot 0 ace, then slot 5 ten held valid until ready
    cyc(1'b1, 3'd0, 4'd1, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      exp_seg[0] = rpat(k);
      cyc(1'b1, 3'd5, 4'd10, 1'b0, 1'b1, 1'b0);
    end
    exp_seg[0] = 7'b0001000;
    cyc(1'b1, 3'd5, 4'd10, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      exp_seg[5] = rpat(k);
      cyc(1'b0, 3'd0, 4'd0, 1'b0, 1'b1, 1'b0);
    end
    exp_seg[5] = 7'b1000000;
    cyc(1'b0, 3'd0, 4'd0, 1'b0, 1'b0, 1'b1);

    // Clear two cycles into a reveal of slot 1 seven
    cyc(1'b1, 3'd1, 4'd7, 1'b0, 1'b0, 1'b1);
    exp_seg[1] = rpat(0);
    cyc(1'b0, 3'd0, 4'd0, 1'b0, 1'b1, 1'b0);
    exp_seg[1] = rpat(1);
    cyc(1'b0, 3'd0, 4'd0, 1'b0, 1'b1, 1'b0);
    exp_seg[1] = rpat(2);
    cyc(1'b0, 3'd0, 4'd0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) exp_seg[i] = BL;
    cyc(1'b1, 3'd3, 4'd9, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) cyc(1'b0, 3'd0, 4'd0, 1'b0, 1'b0, 1'b1);

    // Out-of-range slots are consumed without effect
    cyc(1'b1, 3'd6, 4'd5, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 3'd0, 4'd0, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 3'd7, 4'd5, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 3'd0, 4'd0, 1'b0, 1'b0, 1'b1);

    // Overwrite slot 3 with non-card codes
    do_load(3'd3, 4'd9, 7'b0010000);
    do_load(3'd3, 4'd0, BL);
    do_load(3'd3, 4'd14, BL);
    do_load(3'd3, 4'd15, BL);

    // Remaining decode patterns, back to back across slots
    for (int i = 0; i < 9; i++) do_load(3'(i % 6), tcard[i], tseg[i]);
    cyc(1'b0, 3'd0, 4'd0, 1'b0, 1'b0, 1'b1);

    // Reset mid-reveal: card lost, everything back to reset values
    cyc(1'b1, 3'd4, 4'd8, 1'b0, 1'b0, 1'b1);
    exp_seg[4] = rpat(0);
    cyc(1'b0, 3'd0, 4'd0, 1'b0, 1'b1, 1'b0);
    reset = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || seg7 !== {6{BL}}) begin
      errors++;
      $display("FAIL async_reset: got busy=%b seg7=%h expected busy=0 seg7=%h", busy, seg7, {6{BL}});
    end
    #1;
    reset = 1'b0;
    for (int i = 0; i < 6; i++) exp_seg[i] = BL;
    for (int k = 0; k < 6; k++) cyc(1'b0, 3'd0, 4'd0, 1'b0, 1'b0, 1'b1);

    @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
